// File: rtl/busmem_responder.sv
// Bus responder for the nibble-bus CPU: program store with host loader, 16x4 data RAM, bus-health counters.
// Optional store watchpoint enabled by defining BUSMEM_WATCH_EN (adds watch_addr_i / watch_hit_o).
module busmem_responder #(
  parameter int PROG_AW = 6,
  parameter int FCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        bus_addr_i,
  input  logic [3:0]        bus_ctl_i,
  input  logic [3:0]        bus_wdata_i,
  output logic [3:0]        bus_rdata_o,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [PROG_AW-1:0] ld_addr_i,
  input  logic [11:0]       ld_data_i,
  input  logic              ld_last_i,
  output logic              cpu_rst_n_o,
  output logic [FCNT_W-1:0] fetch_count_o,
  output logic              bus_err_o
`ifdef BUSMEM_WATCH_EN
  ,
  input  logic [3:0]        watch_addr_i,
  output logic              watch_hit_o
`endif
);

  typedef enum logic [1:0] {LOADING, RELEASE, RUN} state_e;

  state_e            state_q, state_d;
  logic [11:0]       pmem_q [0:(1<<PROG_AW)-1];
  logic [3:0]        dmem_q [0:15];
  logic [FCNT_W-1:0] fetch_count_q, fetch_count_d;
  logic              bus_err_q, bus_err_d;

  logic [9:0]  pc;
  logic [1:0]  phase;
  logic        pc_ok;
  logic        daddr_ok;
  logic [11:0] word;
  logic        illegal;
  logic        store_en;
  logic        run;

  assign pc       = {bus_addr_i, bus_ctl_i[3:2]};
  assign phase    = bus_ctl_i[1:0];
  assign pc_ok    = (pc >> PROG_AW) == 10'd0;
  assign daddr_ok = bus_addr_i[7:4] == 4'd0;
  assign word     = pmem_q[pc[PROG_AW-1:0]];
  assign run      = state_q == RUN;

  // Handshake outputs decode straight from the state register so they never glitch.
  assign ld_ready_o    = state_q == LOADING;
  assign cpu_rst_n_o   = run;
  assign fetch_count_o = fetch_count_q;
  assign bus_err_o     = bus_err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOADING: if (ld_valid_i && ld_last_i) state_d = RELEASE;
      RELEASE: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Same-cycle bus decode; the CPU samples bus_rdata_o at the edge ending this cycle.
  always_comb begin
    bus_rdata_o = 4'd0;
    illegal     = 1'b0;
    store_en    = 1'b0;
    if (run) begin
      if (phase != 2'b11) begin
        if (pc_ok) begin
          case (phase)
            2'b00:   bus_rdata_o = word[3:0];
            2'b01:   bus_rdata_o = word[7:4];
            default: bus_rdata_o = word[11:8];
          endcase
        end else begin
          illegal = 1'b1;
        end
      end else if (!bus_ctl_i[3]) begin
        if (!daddr_ok)         illegal     = 1'b1;
        else if (bus_ctl_i[2]) bus_rdata_o = dmem_q[bus_addr_i[3:0]];
        else                   store_en    = 1'b1;
      end else begin
        illegal = 1'b1;
      end
    end
  end

  always_comb begin
    fetch_count_d = fetch_count_q;
    bus_err_d     = bus_err_q | illegal;
    if (run && phase == 2'b00 && fetch_count_q != {FCNT_W{1'b1}})
      fetch_count_d = fetch_count_q + {{(FCNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOADING;
      fetch_count_q <= '0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_count_q <= fetch_count_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // Program store survives rst so a host can reset the CPU without reloading everything.
  always_ff @(posedge clk) begin
    if (!rst && state_q == LOADING && ld_valid_i)
      pmem_q[ld_addr_i] <= ld_data_i;
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_dmem
    always_ff @(posedge clk) begin
      if (rst)
        dmem_q[gi] <= 4'd0;
      else if (store_en && bus_addr_i[3:0] == 4'(gi))
        dmem_q[gi] <= bus_wdata_i;
    end
  end

`ifdef BUSMEM_WATCH_EN
  logic watch_hit_q;
  always_ff @(posedge clk) begin
    if (rst) watch_hit_q <= 1'b0;
    else     watch_hit_q <= store_en && (bus_addr_i[3:0] == watch_addr_i);
  end
  assign watch_hit_o = watch_hit_q;
`else
  // Default build carries no watchpoint logic.
`endif

endmodule

// File: tb/tb_busmem_responder.sv
// Directed + random bench for busmem_responder against a spec-level reference model.
// Watchpoint checks are compiled in when BUSMEM_WATCH_EN is defined.
module tb_busmem_responder;
  localparam int PROG_AW = 6;
  localparam int FCNT_W  = 16;
  localparam int M_LOAD = 0, M_REL = 1, M_RUN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [7:0]         bus_addr;
  logic [3:0]         bus_ctl, bus_wdata, bus_rdata;
  logic               ld_valid, ld_ready, ld_last, cpu_rst_n, bus_err;
  logic [PROG_AW-1:0] ld_addr;
  logic [11:0]        ld_data;
  logic [FCNT_W-1:0]  fetch_count;
  logic [3:0]         watch_addr;
`ifdef BUSMEM_WATCH_EN
  logic               watch_hit;
`endif

  busmem_responder #(.PROG_AW(PROG_AW), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst(rst),
    .bus_addr_i(bus_addr), .bus_ctl_i(bus_ctl), .bus_wdata_i(bus_wdata), .bus_rdata_o(bus_rdata),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .ld_last_i(ld_last), .cpu_rst_n_o(cpu_rst_n), .fetch_count_o(fetch_count), .bus_err_o(bus_err)
`ifdef BUSMEM_WATCH_EN
    , .watch_addr_i(watch_addr), .watch_hit_o(watch_hit)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [11:0] pm [64];
  logic [3:0]  dm [16];
  int          m_mode;
  int          m_count;
  bit          m_err;
  bit          m_watch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_rdata(input logic [7:0] a, input logic [3:0] c);
    int pc = int'(a) * 4 + int'(c[3:2]);
    int ph = int'(c[1:0]);
    logic [11:0] w;
    if (m_mode != M_RUN) return 4'd0;
    if (ph < 3) begin
      if (pc >= 64) return 4'd0;
      w = pm[pc];
      return w[4*ph +: 4];
    end
    if (c == 4'h7 && a < 8'd16) return dm[a[3:0]];
    return 4'd0;
  endfunction

  function automatic bit is_illegal(input logic [7:0] a, input logic [3:0] c);
    int pc = int'(a) * 4 + int'(c[3:2]);
    if (m_mode != M_RUN) return 1'b0;
    if (c[1:0] != 2'b11) return pc >= 64;
    if (c == 4'h3 || c == 4'h7) return a >= 8'd16;
    return 1'b1;
  endfunction

  // One bus cycle: drive, check combinational read, clock, update model, check registered outputs.
  task automatic step(input bit r, input bit v, input logic [5:0] la, input logic [11:0] ld,
                      input bit last, input logic [7:0] ba, input logic [3:0] bc,
                      input logic [3:0] wd, input string tag, input int want);
    rst = r; ld_valid = v; ld_addr = la; ld_data = ld; ld_last = last;
    bus_addr = ba; bus_ctl = bc; bus_wdata = wd;
    #1;
    chk({tag, ".rdata"}, 32'(bus_rdata), 32'(exp_rdata(ba, bc)));
    if (want >= 0) chk({tag, ".rdata_plan"}, 32'(bus_rdata), want);
    @(posedge clk);
    m_watch = 1'b0;
    if (r) begin
      m_mode = M_LOAD; m_count = 0; m_err = 1'b0;
      for (int k = 0; k < 16; k++) dm[k] = 4'd0;
    end else begin
      case (m_mode)
        M_LOAD: if (v) begin
          pm[la] = ld;
          if (last) m_mode = M_REL;
        end
        M_REL: m_mode = M_RUN;
        default: begin
          if (is_illegal(ba, bc)) m_err = 1'b1;
          if (bc == 4'h3 && ba < 8'd16) begin
            dm[ba[3:0]] = wd;
            m_watch = (ba[3:0] == watch_addr);
          end
          if (bc[1:0] == 2'b00 && m_count < 65535) m_count++;
        end
      endcase
    end
    @(negedge clk);
    chk({tag, ".ld_ready"},  32'(ld_ready),  32'(m_mode == M_LOAD));
    chk({tag, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'(m_mode == M_RUN));
    chk({tag, ".bus_err"},   32'(bus_err),   32'(m_err));
    chk({tag, ".fetch_cnt"}, 32'(fetch_count), 32'(m_count));
`ifdef BUSMEM_WATCH_EN
    chk({tag, ".watch_hit"}, 32'(watch_hit), 32'(m_watch));
`endif
  endtask

  task automatic bus(input logic [7:0] ba, input logic [3:0] bc, input logic [3:0] wd,
                     input string tag, input int want);
    step(1'b0, 1'b0, 6'd0, 12'd0, 1'b0, ba, bc, wd, tag, want);
  endtask

  initial begin
    logic [3:0] bc;
    logic [7:0] ba;
    watch_addr = 4'h3;
    rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    bus_addr = '0; bus_ctl = '0; bus_wdata = '0;
    repeat (2) @(posedge clk);
    m_mode = M_LOAD; m_count = 0; m_err = 1'b0; m_watch = 1'b0;
    for (int k = 0; k < 16; k++) dm[k] = 4'd0;
    @(negedge clk);

    // Reset state, then load with junk bus traffic that must be ignored
    step(1, 0, 0, 0, 0, 8'h00, 4'h0, 4'h0, "reset", 0);
    chk("reset.ld_ready_plan", 32'(ld_ready), 1);
    step(0, 1, 0, 12'h4E1, 0, 8'h05, 4'h3, 4'hF, "ld0", 0);
    step(0, 1, 1, 12'h123, 0, 8'h00, 4'hF, 4'h0, "ld1", 0);
    step(0, 1, 2, 12'hABC, 1, 8'h10, 4'h0, 4'h0, "ld2", 0);
    chk("release.ld_ready_plan",  32'(ld_ready),  0);
    chk("release.cpu_rst_n_plan", 32'(cpu_rst_n), 0);
    step(0, 1, 0, 12'hFFF, 1, 8'h00, 4'h0, 4'h0, "release_valid", 0);
    chk("run.cpu_rst_n_plan",   32'(cpu_rst_n), 1);
    chk("run.fetch_count_plan", 32'(fetch_count), 0);

    // Fetches of the loaded words
    bus(8'h00, 4'b0100, 0, "pc1_f1", 3);
    bus(8'h00, 4'b0101, 0, "pc1_f2", 2);
    bus(8'h00, 4'b0110, 0, "pc1_f3", 1);
    bus(8'h00, 4'b0000, 0, "pc0_f1", 1);
    bus(8'h00, 4'b0001, 0, "pc0_f2", 14);
    bus(8'h00, 4'b0010, 0, "pc0_f3", 4);
    bus(8'h00, 4'b1010, 0, "pc2_f3", 10);

    // Store then load; loading-phase store must not have landed
    bus(8'h05, 4'b0111, 0,    "load5_pre", 0);
    bus(8'h05, 4'b0011, 4'h9, "store5", 0);
    bus(8'h05, 4'b0111, 0,    "load5", 9);
    chk("store_load.bus_err_plan", 32'(bus_err), 0);

    // Out-of-range fetch and data access
    bus(8'h10, 4'b0000, 0, "pc40_f1", 0);
    chk("pc40.bus_err_plan", 32'(bus_err), 1);
    bus(8'h15, 4'b0111, 0, "load15", 0);
    bus(8'h00, 4'b0001, 0, "idle", -1);
    chk("sticky.bus_err_plan", 32'(bus_err), 1);

    // Full reload with random gaps and random bus noise
    step(1, 0, 0, 0, 0, 8'h00, 4'h0, 4'h0, "reset2", -1);
    chk("reset2.bus_err_plan", 32'(bus_err), 0);
    for (int i = 0; i < 64; i++) begin
      while ($urandom_range(0, 3) == 0)
        step(0, 0, 6'($urandom), 12'($urandom), 1'($urandom), 8'($urandom), 4'($urandom),
             4'($urandom), "ld_gap", -1);
      step(0, 1, 6'(i), 12'($urandom), i == 63, 8'($urandom), 4'($urandom), 4'($urandom),
           "ld_full", -1);
    end
    bus(8'h00, 4'h0, 0, "release2", -1);

    // Random legal traffic
    for (int i = 0; i < 300; i++) begin
      ba = 8'($urandom_range(0, 15));
      bc = 4'($urandom);
      if (bc[1:0] == 2'b11) bc[3] = 1'b0;
      bus(ba, bc, 4'($urandom), "rand_legal", -1);
    end
    chk("rand_legal.bus_err_plan", 32'(bus_err), 0);

    // Random traffic including illegal cycles
    for (int i = 0; i < 300; i++) begin
      ba = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      bus(ba, 4'($urandom), 4'($urandom), "rand_any", -1);
    end

    // Fetch counter saturation
    for (int i = 0; i < 65600; i++)
      bus(8'($urandom_range(0, 15)), 4'b0000, 0, "sat", -1);
    chk("sat.fetch_count_plan", 32'(fetch_count), 32'hFFFF);

    // Reset mid-run; program store survives, single-beat reload
    step(1, 0, 0, 0, 0, 8'h00, 4'h0, 4'h0, "rst_midrun", -1);
    chk("midrun.fetch_count_plan", 32'(fetch_count), 0);
    chk("midrun.cpu_rst_n_plan",   32'(cpu_rst_n), 0);
    chk("midrun.ld_ready_plan",    32'(ld_ready), 1);
    step(0, 1, 7, 12'h5A6, 1, 8'h00, 4'h0, 4'h0, "reload", -1);
    bus(8'h00, 4'h0, 0, "release3", -1);
    bus(8'h01, 4'b1100, 0, "pc7_f1", 6);
    bus(8'h01, 4'b1110, 0, "pc7_f3", 5);
    for (int p = 0; p < 64; p++)
      for (int ph = 0; ph < 3; ph++)
        bus(8'(p / 4), {2'(p % 4), 2'(ph)}, 0, "retained", -1);
    bus(8'h05, 4'b0111, 0, "load5_cleared", 0);

`ifdef BUSMEM_WATCH_EN
    bus(8'h03, 4'b0011, 4'h7, "watch_store3", -1);
    chk("watch3.watch_hit_plan", 32'(watch_hit), 1);
    bus(8'h00, 4'b0001, 0, "watch_idle", -1);
    chk("watch_idle.watch_hit_plan", 32'(watch_hit), 0);
    bus(8'h04, 4'b0011, 4'h2, "watch_store4", -1);
    chk("watch4.watch_hit_plan", 32'(watch_hit), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
